// File: rtl/fsm_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a pending-byte
// flag with sticky framing-error and overrun indications for software.
`timescale 1ns/1ps
module fsm_uart_rx #(
    parameter int unsigned CLK_FREQ_HZ = 10_000_000,
    parameter int unsigned BAUD        = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       clr_i,
    output logic [7:0] data_o,
    output logic       we_o,
    output logic       new_rx_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] CntBitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalfLast = CntW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone,
        StWaitHi
    } state_e;

    logic            r_sync1;
    logic            r_sync2;
    logic            w_rxs;
    state_e          r_state;
    state_e          w_state_nxt;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic [7:0]      r_data;
    logic [7:0]      w_data_nxt;
    logic            r_new_rx;
    logic            w_new_rx_nxt;
    logic            r_frame_err;
    logic            w_frame_err_nxt;
    logic            r_overrun;
    logic            w_overrun_nxt;
    logic            w_we;

    // Synchronize the asynchronous serial line; idle level is high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // State, bit timing, shift register and software-visible flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_new_rx    <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_new_rx    <= w_new_rx_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state and datapath updates; flag sets in the case below override clr_i.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        w_new_rx_nxt    = r_new_rx;
        w_frame_err_nxt = r_frame_err;
        w_overrun_nxt   = r_overrun;
        w_we            = 1'b0;

        if (clr_i) begin
            w_new_rx_nxt    = 1'b0;
            w_frame_err_nxt = 1'b0;
            w_overrun_nxt   = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (!w_rxs) begin
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                if (r_cnt == CntHalfLast) begin
                    w_cnt_nxt   = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    w_state_nxt = w_rxs ? StIdle : StData;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            StData: begin
                if (r_cnt == CntBitLast) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxs, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = StStop;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            StStop: begin
                if (r_cnt == CntBitLast) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        // Load here so data_o is already valid while we_o is high.
                        w_data_nxt  = r_shift;
                        w_state_nxt = StDone;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = StWaitHi;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            StDone: begin
                w_we         = 1'b1;
                w_new_rx_nxt = 1'b1;
                if (r_new_rx && !clr_i) begin
                    w_overrun_nxt = 1'b1;
                end
                w_state_nxt = StIdle;
            end
            StWaitHi: begin
                // Hold off until the line returns high so a break is one error.
                if (w_rxs) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign data_o      = r_data;
    assign we_o        = w_we;
    assign new_rx_o    = r_new_rx;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_fsm_uart_rx.sv
// Directed bench for fsm_uart_rx, run at 105 clocks per bit (half bit 52).
`timescale 1ns/1ps
module tb_fsm_uart_rx;

    localparam int Cpb  = 105;  // 10_000_000 / 95_000, floored
    localparam int Half = 52;   // 105 / 2, floored

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic       clr_i;
    logic [7:0] data_o;
    logic       we_o;
    logic       new_rx_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         we_cnt = 0;
    int         we_cyc = 0;
    logic [7:0] we_data = 8'h00;
    int         fall_cyc = 0;
    int         base = 0;

    fsm_uart_rx #(
        .CLK_FREQ_HZ(10_000_000),
        .BAUD       (95_000)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .clr_i      (clr_i),
        .data_o     (data_o),
        .we_o       (we_o),
        .new_rx_o   (new_rx_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .busy_o     (busy_o)
    );

    always #50 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every write-enable cycle and the byte presented with it.
    always @(negedge clk_i) begin
        if (rst_i && we_o) begin
            we_cnt  <= we_cnt + 1;
            we_data <= data_o;
            we_cyc  <= cyc;
        end
    end

    task automatic tick(input bit clr_on_we);
        @(posedge clk_i);
        #1;
        clr_i = clr_on_we && we_o;
    endtask

    task automatic hold(input logic v, input int n, input bit clr_on_we);
        rx_i = v;
        repeat (n) tick(clr_on_we);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit clr_on_we);
        fall_cyc = cyc;
        hold(1'b0, Cpb, clr_on_we);
        for (int i = 0; i < 8; i++) hold(b[i], Cpb, clr_on_we);
        hold(stop, Cpb, clr_on_we);
    endtask

    task automatic clr_pulse();
        clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        rx_i  = 1'b1;
        clr_i = 1'b0;
        #10;
        rst_i = 1'b0;
        repeat (3) tick(1'b0);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we_o); end
        checks++; if ({new_rx_o, frame_err_o, overrun_o} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {new_rx_o, frame_err_o, overrun_o});
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst_i = 1'b1;
        hold(1'b1, 10, 1'b0);
    endtask

    task automatic test_single_byte();
        base = we_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        hold(1'b1, 20, 1'b0);
        checks++; if (we_cnt - base != 1) begin errors++; $display("FAIL single_we_count: got %0d want 1", we_cnt - base); end
        checks++; if (we_data !== 8'hA5) begin errors++; $display("FAIL single_we_data: got %h want a5", we_data); end
        // Falling edge driven in cycle F: rxs low at F+2, stop sampled F+2+52+945, DONE one later.
        checks++; if (we_cyc - fall_cyc != 1000) begin
            errors++; $display("FAIL single_we_timing: got %0d want 1000", we_cyc - fall_cyc);
        end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", data_o); end
        checks++; if (new_rx_o !== 1'b1) begin errors++; $display("FAIL single_new_rx: got %b want 1", new_rx_o); end
        checks++; if ({frame_err_o, overrun_o} !== 2'b00) begin
            errors++; $display("FAIL single_flags: got %b want 00", {frame_err_o, overrun_o});
        end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy_o); end
        clr_pulse();
        checks++; if (new_rx_o !== 1'b0) begin errors++; $display("FAIL single_clr: got %b want 0", new_rx_o); end
    endtask

    task automatic test_glitch();
        base = we_cnt;
        hold(1'b0, 10, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy_o); end
        hold(1'b0, 10, 1'b0);
        hold(1'b1, Half + 4 - 20, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", busy_o); end
        checks++; if (we_cnt != base) begin errors++; $display("FAIL glitch_we: got %0d want 0", we_cnt - base); end
        checks++; if ({new_rx_o, frame_err_o, overrun_o} !== 3'b000) begin
            errors++; $display("FAIL glitch_flags: got %b want 000", {new_rx_o, frame_err_o, overrun_o});
        end
        hold(1'b1, 20, 1'b0);
    endtask

    task automatic test_framing_error();
        base = we_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 3 * Cpb, 1'b0);
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", frame_err_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ferr_waithi: got %b want 1", busy_o); end
        checks++; if (we_cnt != base) begin errors++; $display("FAIL ferr_we: got %0d want 0", we_cnt - base); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h want a5", data_o); end
        checks++; if (new_rx_o !== 1'b0) begin errors++; $display("FAIL ferr_new_rx: got %b want 0", new_rx_o); end
        hold(1'b1, 5, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ferr_idle: got %b want 0", busy_o); end
        clr_pulse();
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL ferr_clr: got %b want 0", frame_err_o); end
        base = we_cnt;
        send_frame(8'h55, 1'b1, 1'b0);
        hold(1'b1, 20, 1'b0);
        checks++; if (we_cnt - base != 1) begin errors++; $display("FAIL ferr_next_we: got %0d want 1", we_cnt - base); end
        checks++; if (data_o !== 8'h55) begin errors++; $display("FAIL ferr_next_data: got %h want 55", data_o); end
        checks++; if ({new_rx_o, frame_err_o, overrun_o} !== 3'b100) begin
            errors++; $display("FAIL ferr_next_flags: got %b want 100", {new_rx_o, frame_err_o, overrun_o});
        end
        clr_pulse();
    endtask

    task automatic test_overrun();
        base = we_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        hold(1'b1, 20, 1'b0);
        checks++; if (we_cnt - base != 2) begin errors++; $display("FAIL ovr_we_count: got %0d want 2", we_cnt - base); end
        checks++; if (data_o !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h want 22", data_o); end
        checks++; if ({new_rx_o, overrun_o} !== 2'b11) begin
            errors++; $display("FAIL ovr_flags: got %b want 11", {new_rx_o, overrun_o});
        end
        clr_pulse();
        checks++; if ({new_rx_o, overrun_o} !== 2'b00) begin
            errors++; $display("FAIL ovr_clr: got %b want 00", {new_rx_o, overrun_o});
        end
    endtask

    task automatic test_clr_and_done();
        base = we_cnt;
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b1);
        hold(1'b1, 20, 1'b0);
        checks++; if (we_cnt - base != 2) begin errors++; $display("FAIL same_we_count: got %0d want 2", we_cnt - base); end
        checks++; if (data_o !== 8'h44) begin errors++; $display("FAIL same_data: got %h want 44", data_o); end
        checks++; if ({new_rx_o, overrun_o} !== 2'b10) begin
            errors++; $display("FAIL same_flags: got %b want 10", {new_rx_o, overrun_o});
        end
    endtask

    task automatic test_reset_mid_frame();
        // new_rx_o and data_o = 44 still pending from the previous scenario.
        hold(1'b0, Cpb, 1'b0);
        for (int i = 0; i < 4; i++) hold(1'b0, Cpb, 1'b0);  // 0xF0 bits 0..3
        hold(1'b1, Cpb / 2, 1'b0);                          // middle of bit 4
        rst_i = 1'b0;
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_o); end
        checks++; if ({we_o, new_rx_o, frame_err_o, overrun_o, busy_o} !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want 00000", {we_o, new_rx_o, frame_err_o, overrun_o, busy_o});
        end
        hold(1'b1, 3, 1'b0);
        rst_i = 1'b1;
        hold(1'b1, 20, 1'b0);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b want 0", busy_o); end
        base = we_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        hold(1'b1, 20, 1'b0);
        checks++; if (we_cnt - base != 1) begin errors++; $display("FAIL midrst_we: got %0d want 1", we_cnt - base); end
        checks++; if (data_o !== 8'h81) begin errors++; $display("FAIL midrst_new_data: got %h want 81", data_o); end
        checks++; if ({new_rx_o, frame_err_o, overrun_o} !== 3'b100) begin
            errors++; $display("FAIL midrst_flags: got %b want 100", {new_rx_o, frame_err_o, overrun_o});
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_framing_error();
        test_overrun();
        test_clr_and_done();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_uart_rx.md
# fsm_uart_rx

Receive-side companion to the UART transmit control FSM in the peripheral bus. It deserializes 8N1 frames from the `rx_i` pin and samples each bit at mid-bit time. Each valid byte is written to the UART receive data register with a one-cycle write-enable, and the receive control bit stays set until software clears it. Framing errors and overruns (a new byte arriving before software read the previous one) are flagged for the processor.

## Interface
- `CLK_FREQ_HZ`, 10_000_000, system clock frequency.
- `BAUD`, 9600, line rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD` (integer floor, 1041 at defaults). `HALF_BIT = CLKS_PER_BIT / 2` (520).

Ports:
- `clk_i` in 1: system clock (10 MHz).
- `rst_i` in 1: asynchronous, active-low reset.
- `rx_i` in 1: serial input, idle high, asynchronous to `clk_i`.
- `clr_i` in 1: single-cycle pulse; software has read the byte (writes 0 to the receive control bit).
- `data_o` out 8: last received byte.
- `we_o` out 1: one-cycle pulse; writes `data_o` to the data register and sets the control bit.
- `new_rx_o` out 1: level; an unread byte is pending.
- `frame_err_o` out 1: sticky; stop bit sampled low.
- `overrun_o` out 1: sticky; a byte was overwritten while `new_rx_o` was 1.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- `rx_i` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized signal `rxs`.
- States: IDLE, START, DATA, STOP, DONE, WAITHI. One bit-timing counter `cnt` and one 3-bit bit index `idx`.
- **IDLE:** `cnt` = 0. When `rxs` is 0, go to START.
- **START:** count to `HALF_BIT`-1.
  - If `rxs` is 0 at that point, go to DATA and clear `cnt`.
  - Otherwise it was a glitch: return to IDLE with no flag set.
- **DATA:** each time `cnt` reaches `CLKS_PER_BIT`-1, sample `rxs` into the shift register (LSB first, shifted in from the MSB side), clear `cnt`, and increment `idx`. After the 8th sample (`idx` wraps 7→0), go to STOP.
- **STOP:** when `cnt` reaches `CLKS_PER_BIT`-1, sample `rxs`.
  - If 1, go to DONE.
  - If 0, set `frame_err_o`, discard the byte (`data_o` unchanged, no `we_o`), and go to WAITHI.
- **DONE (exactly one cycle):**
  - `data_o` ← shift register; `we_o` = 1; `new_rx_o` ← 1.
  - If `new_rx_o` was already 1 and `clr_i` is not asserted this cycle, set `overrun_o`. The new byte still overwrites `data_o`.
  - Next state is IDLE.
- **WAITHI:** stay until `rxs` is 1, then go to IDLE. A break condition produces one frame error, not repeated frames.
- **`clr_i`:** clears `new_rx_o`, `frame_err_o` and `overrun_o` on the next edge.
  - If `clr_i` and DONE occur in the same cycle, `new_rx_o` ends at 1 and `overrun_o` is not set: set wins.
  - If `clr_i` and a framing error occur in the same cycle, `frame_err_o` ends at 1.
- **Reset (asynchronous, any time, including mid-frame):**
  - State goes to IDLE; `cnt`, `idx` and the shift register go to 0.
  - `data_o` = 0x00; `we_o`, `new_rx_o`, `frame_err_o`, `overrun_o`, `busy_o` = 0.
  - A partially received frame is dropped. After reset, reception restarts at the next falling edge seen in IDLE.

## Timing
- t0 is the first cycle `rxs` = 0 in IDLE. `rxs` lags `rx_i` by 2 cycles.
- Start validation at t0+`HALF_BIT` (t0+520).
- Data bit k (k = 0..7) is sampled at t0+`HALF_BIT`+(k+1)·`CLKS_PER_BIT` (bit 0 at t0+1561).
- Stop bit sampled at t0+`HALF_BIT`+9·`CLKS_PER_BIT` (t0+9889). `we_o` is high during cycle t0+9890, and `new_rx_o` rises on that cycle's closing edge.
- Back-to-back frames: IDLE is re-entered half a bit before the stop bit ends. A start bit immediately following the stop bit is caught without loss.
- `busy_o` is combinational from state: 0 in IDLE, 1 in all other states.
- Tolerance: sampling drift is ≤ ±4% across the frame at the default parameters.

## Test plan
- **Single byte:** drive 0xA5 at 9600 baud, idle high before and after → `we_o` pulses once for 1 cycle, `data_o` = 0xA5, `new_rx_o` = 1, no flags; then `clr_i` → `new_rx_o` = 0.
- **Glitch rejection:** 200-cycle low pulse on `rx_i` → returns to IDLE, no `we_o`, all flags 0, `busy_o` back to 0 within 522 cycles.
- **Framing error:** 0x3C sent with stop bit low, line held low for 3 bit times → `frame_err_o` = 1, no `we_o`, `data_o` unchanged, FSM stays in WAITHI until the line goes high; a following 0x55 is received correctly.
- **Overrun:** 0x11 then 0x22 back-to-back with no `clr_i` → two `we_o` pulses, `data_o` = 0x22, `overrun_o` = 1; `clr_i` clears both flags.
- **Simultaneous clear and DONE:** `clr_i` asserted in the DONE cycle of the second byte → `new_rx_o` = 1, `overrun_o` = 0, `data_o` = second byte.
- **Reset mid-frame:** assert `rst_i` low during data bit 4 of 0xF0 → all outputs 0 immediately; after release, a fresh 0x81 is received with `data_o` = 0x81 and no flags.
